systolic_seq: RTL and testbench
===============================

# systolic_seq

Sequencer for the ROWS x COLS output-stationary systolic PE array. On `start` it:

- clears the array accumulators;
- streams `k_len` operand vectors from the weight and activation buffers;
- applies the per-lane diagonal skew and drives the array `fire` wavefront;
- waits for the wavefront to drain, then pulses `done`.

It sits between the operand buffers and the array inputs.

## Interface

Parameters:
- `ROWS`, 4, array rows; weight lanes.
- `COLS`, 4, array columns; activation lanes.
- `K_MAX`, 16, maximum inner dimension per job.
- `KW`, $clog2(K_MAX+1), width of `k_len`.
- `AW`, $clog2(K_MAX), buffer address width.

Ports:
- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: one clock; reset is synchronous and active-high.
- `start`, in, 1: job request, sampled only in IDLE.
- `k_len`, in, KW: inner dimension, latched when `start` is accepted.
- `busy`, out, 1: high from the accept cycle through the DONE cycle.
- `done`, out, 1: one-cycle completion pulse.
- `rd_en`, out, 1: buffer read strobe.
- `rd_addr`, out, AW: buffer read index k.
- `w_rdata`, in, 8 x ROWS: weight vector, valid the cycle after `rd_en`.
- `a_rdata`, in, 8 x COLS: activation vector, valid the cycle after `rd_en`.
- `arr_clr`, out, 1: accumulator clear pulse to the array.
- `arr_fire`, out, 1: fire input of PE(0,0).
- `arr_w`, out, 8 x ROWS: skewed weight lanes.
- `arr_a`, out, 8 x COLS: skewed activation lanes.

## Operation

States and transitions:
- IDLE: go to CLEAR when `start`=1. Latch `kl = min(k_len, K_MAX)`. `busy` rises in this accept cycle.
- CLEAR (1 cycle): `arr_clr`=1; reset the k counter to 0. Go to FEED if `kl`>0, otherwise to DONE.
- FEED (`kl` cycles): `rd_en`=1, `rd_addr`=k, k increments each cycle. Go to DRAIN when k = `kl`-1.
- DRAIN (D = ROWS+COLS cycles): no reads. Go to DONE when the drain counter reaches D-1.
- DONE (1 cycle): `done`=1, `busy`=1. Go to IDLE.

Operand path:
- Lane-valid `v0` is `rd_en` delayed 1 cycle.
- `arr_fire` = `v0`.
- Lane 0 outputs `w_rdata[0]`/`a_rdata[0]` when `v0`=1, else 0.
- Lane i (i≥1) is the lane-0-style gated value delayed through i registers.
- Each lane carries zeros outside its valid window. No stale data may leak between jobs.

Other rules:
- `start` is ignored while `busy`=1, including in the DONE cycle.
- `k_len` is sampled only at accept; later changes have no effect.
- Widths: k counter and drain counter each wide enough for K_MAX and D; no wrap-around within a job.

## Timing

Reset:
- `rst`=1 for one cycle: state IDLE; all skew registers, counters and outputs are 0. This covers `busy`, `done`, `rd_en`, `rd_addr`, `arr_clr`, `arr_fire`, `arr_w` and `arr_a`.
- `rst` mid-job aborts immediately. No `done` is produced. The next `start` is accepted normally.

For `start` accepted at cycle t with `kl`=K>0:
- CLEAR at t+1.
- `rd_en` high during t+2..t+1+K, with `rd_addr` = 0..K-1.
- `arr_fire` and lane-0 data during t+3..t+2+K.
- Lane i data during t+3+i..t+2+K+i.
- DRAIN during t+2+K..t+1+K+D.
- `done` at t+2+K+D; `busy` falls at t+3+K+D.
- Earliest next accept: t+3+K+D.

For K=0:
- CLEAR at t+1, `done` at t+2.
- No `rd_en` and no `arr_fire`.

## Test plan

- Reset then idle: hold `rst` 3 cycles, then `start`=0 for 10 cycles -> every output stays 0.
- ROWS=COLS=4, `k_len`=3, buffer word k = k+1 on all lanes, `start` at t:
  - `arr_clr` at t+1; `rd_addr` 0,1,2 at t+2..t+4.
  - `arr_w[0]` = 1,2,3 at t+3..t+5; `arr_w[3]` = 1,2,3 at t+6..t+8.
  - `done` at t+13.
- `k_len`=0 -> `done` at t+2; `rd_en` and `arr_fire` never asserted.
- `k_len`=20 with K_MAX=16 -> exactly 16 reads, addresses 0..15, `done` at t+26.
- `start` held high continuously with `k_len`=2 -> jobs accepted at t and t+13 only; no accepts while `busy`.
- `rst` asserted at t+4 of a `k_len`=8 job -> all outputs 0 next cycle, no `done`; a fresh `start` then completes normally.

Source files
------------

// File: rtl/systolic_seq.sv
// Job sequencer for an output-stationary ROWS x COLS systolic array: clears the
// accumulators, streams k_len operand vectors with diagonal skew, drains, then pulses done.
module systolic_seq #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int AW    = $clog2(K_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [8*ROWS-1:0]    w_rdata,
    input  logic [8*COLS-1:0]    a_rdata,
    output logic                 arr_clr,
    output logic                 arr_fire,
    output logic [8*ROWS-1:0]    arr_w,
    output logic [8*COLS-1:0]    arr_a
);

    localparam int D  = ROWS + COLS;
    localparam int DW = $clog2(D + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t        state;
    logic [KW-1:0] kl;
    logic [KW-1:0] k;
    logic [DW-1:0] dcnt;
    logic          v0;

    // The accept cycle counts as busy, so start is folded in combinationally.
    assign busy = (state != IDLE) || (start && !rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kl      <= '0;
            k       <= '0;
            dcnt    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            arr_clr <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only by the transition
            // that enters their state, so each output is a flop rather than a state decode.
            arr_clr <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            case (state)
                IDLE: if (start) begin
                    kl      <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                    arr_clr <= 1'b1;
                    state   <= CLEAR;
                end
                CLEAR: begin
                    k    <= '0;
                    dcnt <= '0;
                    if (kl != '0) begin
                        rd_en <= 1'b1;
                        state <= FEED;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                FEED: begin
                    if (k == kl - 1'b1) begin
                        state <= DRAIN;
                    end else begin
                        k       <= k + 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= AW'(k + 1'b1);
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(D - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) v0 <= 1'b0;
        else     v0 <= rd_en;
    end

    assign arr_fire = v0;

    // Lane i is the v0-gated buffer word delayed by i flops; gating keeps lanes zero between jobs.
    for (genvar i = 0; i < ROWS; i++) begin : g_w
        logic [7:0] gated;
        assign gated = v0 ? w_rdata[8*i +: 8] : 8'd0;
        if (i == 0) begin : g_l0
            assign arr_w[7:0] = gated;
        end else begin : g_skew
            logic [7:0] pipe [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    // NOTE: the skew flops are cleared on reset so an aborted job cannot leak operands.
                    for (int j = 0; j < i; j++) pipe[j] <= '0;
                end else begin
                    pipe[0] <= gated;
                    for (int j = 1; j < i; j++) pipe[j] <= pipe[j-1];
                end
            end
            assign arr_w[8*i +: 8] = pipe[i-1];
        end
    end

    for (genvar i = 0; i < COLS; i++) begin : g_a
        logic [7:0] gated;
        assign gated = v0 ? a_rdata[8*i +: 8] : 8'd0;
        if (i == 0) begin : g_l0
            assign arr_a[7:0] = gated;
        end else begin : g_skew
            logic [7:0] pipe [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < i; j++) pipe[j] <= '0;
                end else begin
                    pipe[0] <= gated;
                    for (int j = 1; j < i; j++) pipe[j] <= pipe[j-1];
                end
            end
            assign arr_a[8*i +: 8] = pipe[i-1];
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: stimulus pushes per-cycle expected events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_systolic_seq;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int K_MAX = 16;
    localparam int KW    = 5;
    localparam int AW    = 4;
    localparam int D     = ROWS + COLS;
    localparam int NEVER = 1 << 30;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [8*ROWS-1:0]    w_rdata;
    logic [8*COLS-1:0]    a_rdata;
    logic                 arr_clr;
    logic                 arr_fire;
    logic [8*ROWS-1:0]    arr_w;
    logic [8*COLS-1:0]    arr_a;

    systolic_seq #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .KW(KW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .w_rdata(w_rdata), .a_rdata(a_rdata),
        .arr_clr(arr_clr), .arr_fire(arr_fire), .arr_w(arr_w), .arr_a(arr_a)
    );

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t rd_q[$];
    ev_t clr_q[$];
    ev_t fire_q[$];
    ev_t done_q[$];
    ev_t wq[ROWS][$];
    ev_t aq[COLS][$];
    bit  busy_map[int];

    int cyc    = 0;
    int tests  = 0;
    int fails  = 0;
    bit mon_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous buffer model: word k is k+1 on weight lanes, 16*(j+1)+k+1 on activation lane j.
    always @(posedge clk) begin
        for (int i = 0; i < ROWS; i++)
            w_rdata[8*i +: 8] <= rd_en ? 8'(rd_addr) + 8'd1 : 8'hA5;
        for (int j = 0; j < COLS; j++)
            a_rdata[8*j +: 8] <= rd_en ? 8'(16*(j+1)) + 8'(rd_addr) + 8'd1 : 8'h5A;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    // Expected events for a job accepted in cycle t with clamped length kk; events after cut are dropped.
    task automatic push_job(input int t, input int kk, input int cut);
        int last;
        last = (kk == 0) ? t + 2 : t + 2 + kk + D;
        if (t + 1 <= cut) clr_q.push_back(mk(t + 1, 0));
        for (int k = 0; k < kk; k++) begin
            if (t + 2 + k <= cut) rd_q.push_back(mk(t + 2 + k, k));
            if (t + 3 + k <= cut) fire_q.push_back(mk(t + 3 + k, 0));
        end
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < kk; k++)
                if (t + 3 + i + k <= cut) wq[i].push_back(mk(t + 3 + i + k, k + 1));
        for (int j = 0; j < COLS; j++)
            for (int k = 0; k < kk; k++)
                if (t + 3 + j + k <= cut) aq[j].push_back(mk(t + 3 + j + k, 16*(j+1) + k + 1));
        if (last <= cut) done_q.push_back(mk(last, 0));
        for (int c = t; c <= last && c <= cut; c++) busy_map[c] = 1'b1;
    endtask

    task automatic issue(input int klen, input int klen_after, input int cut_rel);
        int t;
        int kk;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(klen);
        t     = cyc;
        kk    = (klen > K_MAX) ? K_MAX : klen;
        push_job(t, kk, (cut_rel < 0) ? NEVER : t + cut_rel);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = KW'(klen_after);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 64'({busy, done, rd_en, rd_addr, arr_clr, arr_fire}), 64'd0);
        check({name, "_w"}, 64'(arr_w), 64'd0);
        check({name, "_a"}, 64'(arr_a), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_on) begin
            if (rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
                else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(e.cyc));
                    check("rd_addr", 64'(rd_addr), 64'(e.val));
                end
            end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                e = rd_q.pop_front();
                check("rd_missing", 64'd0, 64'd1);
            end

            if (arr_clr) begin
                if (clr_q.size() == 0) check("clr_unexpected", 64'd1, 64'd0);
                else begin
                    e = clr_q.pop_front();
                    check("clr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (clr_q.size() > 0 && clr_q[0].cyc <= cyc) begin
                e = clr_q.pop_front();
                check("clr_missing", 64'd0, 64'd1);
            end

            if (arr_fire) begin
                if (fire_q.size() == 0) check("fire_unexpected", 64'd1, 64'd0);
                else begin
                    e = fire_q.pop_front();
                    check("fire_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (fire_q.size() > 0 && fire_q[0].cyc <= cyc) begin
                e = fire_q.pop_front();
                check("fire_missing", 64'd0, 64'd1);
            end

            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
                else begin
                    e = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
                e = done_q.pop_front();
                check("done_missing", 64'd0, 64'd1);
            end

            for (int i = 0; i < ROWS; i++) begin
                if (wq[i].size() > 0 && wq[i][0].cyc <= cyc) begin
                    e = wq[i].pop_front();
                    check($sformatf("w_lane%0d_c%0d", i, e.cyc), 64'(arr_w[8*i +: 8]), 64'(e.val));
                end else begin
                    check($sformatf("w_lane%0d_zero", i), 64'(arr_w[8*i +: 8]), 64'd0);
                end
            end
            for (int j = 0; j < COLS; j++) begin
                if (aq[j].size() > 0 && aq[j][0].cyc <= cyc) begin
                    e = aq[j].pop_front();
                    check($sformatf("a_lane%0d_c%0d", j, e.cyc), 64'(arr_a[8*j +: 8]), 64'(e.val));
                end else begin
                    check($sformatf("a_lane%0d_zero", j), 64'(arr_a[8*j +: 8]), 64'd0);
                end
            end

            check("busy", 64'(busy), 64'(busy_map.exists(cyc)));
        end
    end

    initial begin : stimulus
        int t;
        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;

        // Reset then idle
        repeat (10) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        // k_len=3, then k_len changed after accept must not matter
        issue(3, 7, -1);
        repeat (20) @(posedge clk);

        // k_len=0: clear then done, no reads or fire
        issue(0, 0, -1);
        repeat (6) @(posedge clk);

        // k_len above K_MAX clamps to 16 reads
        issue(20, 0, -1);
        repeat (32) @(posedge clk);

        // start held high: accepts only at t and t+13
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(2);
        t     = cyc;
        push_job(t, 2, NEVER);
        repeat (13) @(posedge clk);
        #1;
        push_job(cyc, 2, NEVER);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);

        // Reset at t+4 of a k_len=8 job aborts it without done
        issue(8, 8, 4);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_abort");
        repeat (5) @(posedge clk);

        // Fresh job after abort completes normally
        issue(5, 0, -1);
        repeat (25) @(posedge clk);

        @(negedge clk);
        mon_on = 1'b0;
        check("leftover_rd", 64'(rd_q.size()), 64'd0);
        check("leftover_clr", 64'(clr_q.size()), 64'd0);
        check("leftover_fire", 64'(fire_q.size()), 64'd0);
        check("leftover_done", 64'(done_q.size()), 64'd0);
        for (int i = 0; i < ROWS; i++) check("leftover_w", 64'(wq[i].size()), 64'd0);
        for (int j = 0; j < COLS; j++) check("leftover_a", 64'(aq[j].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
